prio_enc_arb: RTL and testbench

//  Parametrised, registered priority encoder/arbiter: latches N request lines into a pending

---
 rtl/prio_enc_arb.sv | 115 +++++++++++
 tb/tb_prio_enc_arb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_arb.sv
// Registered priority encoder / arbiter.
// Latches requests, grants one eligible index per cycle over valid/ready.
module prio_enc_arb #(
  parameter int N = 8,
  parameter int RR = 0,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mask_we,
  input  logic [N-1:0] mask_in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pend,
  output logic         idle
);

  logic [N-1:0] pending;
  logic [N-1:0] mask;
  logic [W-1:0] rr_ptr;
  logic [N-1:0] clr;
  logic [N-1:0] elig;
  logic [W-1:0] sel;
  logic         accept;
  logic         load;

  assign accept = out_valid & out_ready;
  assign load   = ~out_valid | accept;
  assign elig   = pending & mask & ~clr;
  assign pend   = pending;
  assign idle   = (pending == '0) & ~out_valid;

  // One-hot clear of the index being accepted this cycle
  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      if (accept && (out_idx == W'(i))) begin
        clr[i] = 1'b1;
      end
    end
  end

  // Pick the winner: highest index, or nearest below rr_ptr with wrap
  always_comb begin : sel_logic
    int base;
    int d;
    int best;
    sel  = '0;
    base = 0;
    d    = 0;
    best = N;
    if (RR == 0) begin
      for (int i = 0; i < N; i++) begin
        if (elig[i]) begin
          sel = W'(i);
        end
      end
    end else begin
      base = (rr_ptr == '0) ? N - 1 : int'(rr_ptr) - 1;
      for (int i = 0; i < N; i++) begin
        d = base - i;
        if (d < 0) begin
          d = d + N;
        end
        if (elig[i] && (d < best)) begin
          best = d;
          sel  = W'(i);
        end
      end
    end
  end

  // Pending set/clear; a same-cycle request wins over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | req;
    end
  end

  // Eligibility mask, all requests enabled out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '1;
    end else if (mask_we) begin
      mask <= mask_in;
    end
  end

  // Round-robin pointer follows the last accepted index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= out_idx;
    end
  end

  // Output register holds a presented grant until it is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else if (load) begin
      out_valid <= |elig;
      if (|elig) begin
        out_idx <= sel;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed bench for prio_enc_arb.
// Fixed-priority and round-robin instances share one stimulus.
module tb_prio_enc_arb;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       out_ready;

  logic       fp_valid;
  logic [2:0] fp_idx;
  logic [7:0] fp_pend;
  logic       fp_idle;
  logic       rr_valid;
  logic [2:0] rr_idx;
  logic [7:0] rr_pend;
  logic       rr_idle;

  int n_cmp = 0;
  int n_err = 0;

  prio_enc_arb #(.N(8), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .req(req),
    .mask_we(mask_we), .mask_in(mask_in),
    .out_ready(out_ready), .out_valid(fp_valid),
    .out_idx(fp_idx), .pend(fp_pend), .idle(fp_idle)
  );

  prio_enc_arb #(.N(8), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .req(req),
    .mask_we(mask_we), .mask_in(mask_in),
    .out_ready(out_ready), .out_valid(rr_valid),
    .out_idx(rr_idx), .pend(rr_pend), .idle(rr_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fp_state(input string tag, input logic v,
                          input logic [2:0] ix, input logic [7:0] p);
    chk({tag, ".valid"}, 8'(fp_valid), 8'(v));
    if (v) chk({tag, ".idx"}, 8'(fp_idx), 8'(ix));
    chk({tag, ".pend"}, fp_pend, p);
    chk({tag, ".idle"}, 8'(fp_idle), 8'((p == 8'h00) && !v));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    mask_we = 1'b0;
    mask_in = '0;
    out_ready = 1'b0;

    // 1: reset state held over idle cycles
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      fp_state("t1", 1'b0, 3'd0, 8'h00);
    end
    chk("t1.mask", u_fp.mask, 8'hFF);
    chk("t1.rr_idle", 8'(rr_idle), 8'd1);

    // 2: single pulse, three grants in descending order
    out_ready = 1'b1;
    req = 8'hA4;
    step();
    req = 8'h00;
    fp_state("t2.c1", 1'b0, 3'd0, 8'hA4);
    step();
    fp_state("t2.c2", 1'b1, 3'd7, 8'hA4);
    step();
    fp_state("t2.c3", 1'b1, 3'd5, 8'h24);
    step();
    fp_state("t2.c4", 1'b1, 3'd2, 8'h04);
    step();
    fp_state("t2.c5", 1'b0, 3'd0, 8'h00);

    // 3: backpressure keeps the presented grant stable
    out_ready = 1'b0;
    req = 8'h20;
    step();
    req = 8'h00;
    fp_state("t3.c1", 1'b0, 3'd0, 8'h20);
    step();
    fp_state("t3.c2", 1'b1, 3'd5, 8'h20);
    req = 8'h80;
    step();
    req = 8'h00;
    fp_state("t3.c3", 1'b1, 3'd5, 8'hA0);
    step();
    fp_state("t3.c4", 1'b1, 3'd5, 8'hA0);
    out_ready = 1'b1;
    step();
    fp_state("t3.c5", 1'b1, 3'd7, 8'h80);
    step();
    fp_state("t3.c6", 1'b0, 3'd0, 8'h00);

    // 4: masked request stays pending until unmasked
    mask_we = 1'b1;
    mask_in = 8'h7F;
    req = 8'h82;
    step();
    mask_we = 1'b0;
    req = 8'h00;
    fp_state("t4.c1", 1'b0, 3'd0, 8'h82);
    step();
    fp_state("t4.c2", 1'b1, 3'd1, 8'h82);
    step();
    fp_state("t4.c3", 1'b0, 3'd0, 8'h80);
    mask_we = 1'b1;
    mask_in = 8'hFF;
    step();
    mask_we = 1'b0;
    fp_state("t4.c4", 1'b0, 3'd0, 8'h80);
    step();
    fp_state("t4.c5", 1'b1, 3'd7, 8'h80);
    step();
    fp_state("t4.c6", 1'b0, 3'd0, 8'h00);

    // 5: round-robin rotation with all requests held
    do_reset();
    req = 8'hFF;
    out_ready = 1'b1;
    step();
    chk("t5.pend0", rr_pend, 8'hFF);
    chk("t5.valid0", 8'(rr_valid), 8'd0);
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("t5.valid%0d", k + 1), 8'(rr_valid), 8'd1);
      chk($sformatf("t5.idx%0d", k + 1), 8'(rr_idx),
          8'((7 - k + 8) % 8));
      chk($sformatf("t5.pend%0d", k + 1), rr_pend, 8'hFF);
    end
    req = 8'h00;

    // 6: asynchronous reset between edges
    do_reset();
    out_ready = 1'b0;
    req = 8'h3C;
    step();
    req = 8'h00;
    step();
    fp_state("t6.pre", 1'b1, 3'd5, 8'h3C);
    #2;
    rst = 1'b1;
    #1;
    fp_state("t6.rst", 1'b0, 3'd0, 8'h00);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      fp_state($sformatf("t6.post%0d", i), 1'b0, 3'd0, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
